// File: rtl/phy_tx_lane_serializer.sv
// Multi-lane PHY transmit serializer: stripes WIDTH-bit words byte-wise across LANES
// serial outputs (MSB first), with COM sync frames after reset and IDLE fill when starved.
module phy_tx_lane_serializer #(
   parameter int          WIDTH       = 32,
   parameter int          LANES       = 2,
   parameter int          SYNC_FRAMES = 4,
   parameter logic [7:0]  COM         = 8'hBC,
   parameter logic [7:0]  IDLE        = 8'h7C
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [LANES-1:0] serial_o,
   output logic             tx_k,
   output logic             active
);

   localparam int BPL     = WIDTH / (8 * LANES);
   localparam int FRAME_W = 8 * BPL;
   localparam int NBYTES  = WIDTH / 8;
   localparam int IDX_W   = (BPL > 1) ? $clog2(BPL) : 1;
   localparam int SYNC_W  = $clog2(SYNC_FRAMES + 1);

   if (LANES < 1) begin : g_bad_lanes
      $error("phy_tx_lane_serializer: LANES must be >= 1");
   end
   if (WIDTH % (8 * LANES) != 0) begin : g_bad_width
      $error("phy_tx_lane_serializer: WIDTH must be a multiple of 8*LANES");
   end
   if (SYNC_FRAMES < 1) begin : g_bad_sync
      $error("phy_tx_lane_serializer: SYNC_FRAMES must be >= 1");
   end

   typedef enum logic {
      ST_SYNC   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t                          state;
   state_t                          state_next;
   logic [2:0]                      bit_cnt;
   logic [IDX_W-1:0]                byte_idx;
   logic [SYNC_W-1:0]               sync_cnt;
   logic [LANES-1:0][FRAME_W-1:0]   lane_sr;
   logic [LANES-1:0][FRAME_W-1:0]   data_frame;
   logic [LANES-1:0][FRAME_W-1:0]   load_frame;
   logic                            load_k;
   logic [WIDTH-1:0]                hold_data;
   logic                            hold_valid;
   logic                            tx_k_q;
   logic                            frame_end;
   logic                            consume;
   logic                            capture;

   assign frame_end = (bit_cnt == 3'd7) && (byte_idx == IDX_W'(BPL - 1));
   assign active    = (state == ST_ACTIVE);
   assign consume   = frame_end && active && hold_valid;
   assign in_ready  = !hold_valid || (active && frame_end);
   assign capture   = in_valid && in_ready;
   assign tx_k      = tx_k_q;

   for (genvar k = 0; k < LANES; k++) begin : g_serial
      assign serial_o[k] = lane_sr[k][FRAME_W-1];
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state <= ST_SYNC;
      end else begin
         state <= state_next;
      end
   end

   // Leave SYNC on the edge that loads the last COM frame.
   always_comb begin
      state_next = state;
      case (state)
         ST_SYNC: begin
            if (frame_end && (sync_cnt == SYNC_W'(SYNC_FRAMES - 1))) begin
               state_next = ST_ACTIVE;
            end
         end
         ST_ACTIVE: state_next = ST_ACTIVE;
         default:   state_next = ST_SYNC;
      endcase
   end

   // Byte j of the held word lands in lane j%LANES, slot j/LANES (slot 0 sits at the top).
   always_comb begin
      data_frame = '0;
      for (int j = 0; j < NBYTES; j++) begin
         data_frame[j % LANES][FRAME_W-1-8*(j/LANES) -: 8] = hold_data[WIDTH-1-8*j -: 8];
      end
   end

   always_comb begin
      load_frame = '0;
      load_k     = 1'b1;
      if (state == ST_SYNC) begin
         for (int k = 0; k < LANES; k++) begin
            load_frame[k] = {BPL{COM}};
         end
      end else if (hold_valid) begin
         load_frame = data_frame;
         load_k     = 1'b0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            load_frame[k] = {BPL{IDLE}};
         end
      end
   end

   // Reset parks the counters at frame_end so the first edge after release loads a frame.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         bit_cnt  <= 3'd7;
         byte_idx <= IDX_W'(BPL - 1);
         sync_cnt <= '0;
      end else if (frame_end) begin
         bit_cnt  <= 3'd0;
         byte_idx <= '0;
         if (state == ST_SYNC) begin
            sync_cnt <= sync_cnt + SYNC_W'(1);
         end
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         if (bit_cnt == 3'd7) begin
            byte_idx <= byte_idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         lane_sr <= '0;
         tx_k_q  <= 1'b1;
      end else if (frame_end) begin
         lane_sr <= load_frame;
         tx_k_q  <= load_k;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            lane_sr[k] <= {lane_sr[k][FRAME_W-2:0], 1'b0};
         end
      end
   end

   // A capture on a consuming edge refills the holding register in the same cycle.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (capture) begin
         hold_valid <= 1'b1;
         hold_data  <= in_data;
      end else if (consume) begin
         hold_valid <= 1'b0;
      end
   end

endmodule
